// File: rtl/link_tx_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : link_tx_serializer_pkg
// Brief   : Shared link definitions for the Tx serializer and matching receiver.
// Revision: 1.0
// ============================================================================
package link_tx_serializer_pkg;

  localparam int c_PACKET_W = 32;
  localparam int c_LINK_W   = 8;

  // Packet field positions; the destination address leads on the wire.
  localparam int c_DEST_X_MSB  = 31;
  localparam int c_DEST_X_LSB  = 28;
  localparam int c_DEST_Y_MSB  = 27;
  localparam int c_DEST_Y_LSB  = 24;
  localparam int c_RSVD_MSB    = 23;
  localparam int c_RSVD_LSB    = 16;
  localparam int c_PAYLOAD_MSB = 15;
  localparam int c_PAYLOAD_LSB = 0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } link_state_t;

  typedef struct packed {
    logic [3:0]  dest_x;
    logic [3:0]  dest_y;
    logic [7:0]  reserved;
    logic [15:0] payload;
  } link_packet_t;

  function automatic logic [3:0] pkt_dest_x(input logic [c_PACKET_W-1:0] pkt);
    return pkt[c_DEST_X_MSB:c_DEST_X_LSB];
  endfunction

  function automatic logic [3:0] pkt_dest_y(input logic [c_PACKET_W-1:0] pkt);
    return pkt[c_DEST_Y_MSB:c_DEST_Y_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/link_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module  : link_tx_serializer
// Brief   : Pops packets from the Tx queue and sends them MSB-first as flits.
// Revision: 1.0
// ============================================================================
module link_tx_serializer
  import link_tx_serializer_pkg::*;
#(
  parameter int PACKET_W = c_PACKET_W,
  parameter int LINK_W   = c_LINK_W,
  parameter int CNT_W    = 16
) (
  input  logic                Clk_r,
  input  logic                Rst,
  input  logic                Link_Enable,
  input  logic                Queue_Empty,
  input  logic [PACKET_W-1:0] Queue_Packet,
  output logic                Queue_Read,
  output logic [LINK_W-1:0]   Link_Data,
  output logic                Link_Valid,
  output logic                Link_Start,
  input  logic                Link_Ack,
  output logic                Busy,
  output logic [CNT_W-1:0]    Packets_Sent
);

  localparam int FLITS      = PACKET_W / LINK_W;
  localparam int FLIT_CNT_W = (FLITS > 2) ? $clog2(FLITS) : 1;
  localparam logic [FLIT_CNT_W-1:0] c_LAST_FLIT = FLIT_CNT_W'(FLITS - 1);

  generate
    if (FLITS < 2) begin : g_bad_flits
      $error("link_tx_serializer: PACKET_W/LINK_W must be at least 2");
    end
    if ((PACKET_W % LINK_W) != 0) begin : g_bad_width
      $error("link_tx_serializer: PACKET_W must be a multiple of LINK_W");
    end
  endgenerate

  link_state_t            r_state;
  logic [PACKET_W-1:0]    r_shift;
  logic [FLIT_CNT_W-1:0]  r_flit_cnt;

  // The head flit is always the top of the shift register.
  assign Link_Data = r_shift[PACKET_W-1 -: LINK_W];

  always_ff @(posedge Clk_r or posedge Rst) begin
    if (Rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_flit_cnt   <= '0;
      Link_Valid   <= 1'b0;
      Link_Start   <= 1'b0;
      Queue_Read   <= 1'b0;
      Busy         <= 1'b0;
      Packets_Sent <= '0;
    end else begin
      Queue_Read <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Link_Enable && !Queue_Empty) begin
            r_shift    <= Queue_Packet;
            r_flit_cnt <= '0;
            Link_Valid <= 1'b1;
            Link_Start <= 1'b1;
            Queue_Read <= 1'b1;
            Busy       <= 1'b1;
            r_state    <= SEND;
          end
        end
        SEND: begin
          // Without an ack the current flit simply holds; there is no timeout.
          if (Link_Ack) begin
            if (r_flit_cnt == c_LAST_FLIT) begin
              Link_Valid   <= 1'b0;
              Link_Start   <= 1'b0;
              Busy         <= 1'b0;
              Packets_Sent <= Packets_Sent + CNT_W'(1);
              r_state      <= IDLE;
            end else begin
              r_shift    <= r_shift << LINK_W;
              r_flit_cnt <= r_flit_cnt + FLIT_CNT_W'(1);
              Link_Start <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_link_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_link_tx_serializer
// Brief   : Self-checking bench: flit-stream model, vector table, random traffic.
// Revision: 1.0
// ============================================================================
module tb_link_tx_serializer;

  logic        clk;
  logic        rst;
  logic        link_enable;
  logic        queue_empty;
  logic [31:0] queue_packet;
  logic        queue_read;
  logic [7:0]  link_data;
  logic        link_valid;
  logic        link_start;
  logic        link_ack;
  logic        busy;
  logic [15:0] packets_sent;

  logic        s_queue_read;
  logic [7:0]  s_link_data;
  logic        s_link_valid;
  logic        s_link_start;
  logic        s_busy;
  logic [3:0]  s_packets_sent;

  link_tx_serializer dut (
    .Clk_r(clk), .Rst(rst), .Link_Enable(link_enable), .Queue_Empty(queue_empty),
    .Queue_Packet(queue_packet), .Queue_Read(queue_read), .Link_Data(link_data),
    .Link_Valid(link_valid), .Link_Start(link_start), .Link_Ack(link_ack),
    .Busy(busy), .Packets_Sent(packets_sent)
  );

  // Narrow counter copy on the same traffic so counter wrap is reachable quickly.
  link_tx_serializer #(.CNT_W(4)) dut_w4 (
    .Clk_r(clk), .Rst(rst), .Link_Enable(link_enable), .Queue_Empty(queue_empty),
    .Queue_Packet(queue_packet), .Queue_Read(s_queue_read), .Link_Data(s_link_data),
    .Link_Valid(s_link_valid), .Link_Start(s_link_start), .Link_Ack(link_ack),
    .Busy(s_busy), .Packets_Sent(s_packets_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] txq[$];
  logic [7:0]  exp_flits[$];
  logic [7:0]  got_flits[$];
  int          rd_cyc[$];
  int          flit_idx   = 0;
  int          exp_sent   = 0;
  bit          prev_valid = 1'b0;
  bit          last_valid = 1'b0;

  int stat_cyc, first_valid, n_valid_cyc, n_reads, n_hold;
  int hold_idx = -1, stall_len_g = 0, stall_used = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sync_q();
    queue_empty  = (txq.size() == 0);
    queue_packet = (txq.size() == 0) ? 32'h0 : txq[0];
  endtask

  task automatic push_pkt(input logic [31:0] p);
    txq.push_back(p);
    sync_q();
  endtask

  task automatic clear_stats();
    got_flits.delete();
    rd_cyc.delete();
    stat_cyc = 0; first_valid = 0; n_valid_cyc = 0; n_reads = 0; n_hold = 0;
  endtask

  // One cycle: sample at the falling edge, check against the model, drive inputs
  // for the next rising edge. ack_mode 2 stalls hold_idx for stall_len_g cycles.
  task automatic step(input logic en, input int ack_mode);
    logic [31:0] pkt;
    bit          exp_pop;
    logic        ack;
    @(negedge clk);
    stat_cyc++;
    exp_pop = !prev_valid && link_enable && (txq.size() != 0);
    chk("queue_read", queue_read, exp_pop);
    if (queue_read) begin
      n_reads++;
      rd_cyc.push_back(stat_cyc);
      if (txq.size() == 0) begin
        chk("pop_from_empty", 1, 0);
      end else begin
        pkt = txq.pop_front();
        for (int i = 0; i < 4; i++) exp_flits.push_back(8'((pkt >> (24 - 8 * i)) & 32'hFF));
        sync_q();
      end
    end
    chk("link_valid", link_valid, exp_flits.size() != 0);
    if (link_valid && exp_flits.size() != 0) begin
      chk("link_data", link_data, exp_flits[0]);
      chk("link_start", link_start, flit_idx == 0);
    end else begin
      chk("link_start_idle", link_start, 0);
    end
    chk("busy", busy, link_valid);
    chk("packets_sent", packets_sent, exp_sent[15:0]);
    chk("packets_sent_w4", s_packets_sent, exp_sent[3:0]);
    if (link_valid) begin
      n_valid_cyc++;
      if (first_valid == 0) first_valid = stat_cyc;
      if (flit_idx == hold_idx) n_hold++;
    end
    if (ack_mode == 2) begin
      ack = !(link_valid && flit_idx == hold_idx && stall_used < stall_len_g);
      if (!ack) stall_used++;
    end else begin
      ack = (ack_mode != 0);
    end
    link_enable = en;
    link_ack    = ack;
    if (link_valid && ack && exp_flits.size() != 0) begin
      got_flits.push_back(exp_flits.pop_front());
      flit_idx++;
      if (flit_idx == 4) begin
        flit_idx = 0;
        exp_sent++;
      end
    end
    last_valid = link_valid;
    prev_valid = link_valid;
  endtask

  task automatic drain(input int budget, input string name);
    int k;
    k = 0;
    while ((txq.size() != 0 || exp_flits.size() != 0 || prev_valid) && k < budget) begin
      step(1'b1, 1);
      k++;
    end
    chk({name, "_drain_done"}, k < budget, 1);
  endtask

  typedef struct {
    logic [31:0]      pkt;
    int               stall_idx;
    int               stall_len;
    logic [3:0][7:0]  flits;
    int               send_cyc;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          k;
    int          s0;
    logic [9:0]  vb;
    logic [7:0]  b2b[8];

    vecs[0] = '{pkt: 32'h3400DEAD, stall_idx: -1, stall_len: 0,
                flits: {8'h34, 8'h00, 8'hDE, 8'hAD}, send_cyc: 4};
    vecs[1] = '{pkt: 32'h1100BEEF, stall_idx: 2, stall_len: 3,
                flits: {8'h11, 8'h00, 8'hBE, 8'hEF}, send_cyc: 7};
    vecs[2] = '{pkt: 32'h3200FACE, stall_idx: 0, stall_len: 1,
                flits: {8'h32, 8'h00, 8'hFA, 8'hCE}, send_cyc: 5};
    vecs[3] = '{pkt: 32'hA5C30F1E, stall_idx: 3, stall_len: 2,
                flits: {8'hA5, 8'hC3, 8'h0F, 8'h1E}, send_cyc: 6};
    b2b = '{8'h34, 8'h00, 8'hCA, 8'hFE, 8'h43, 8'h00, 8'hFE, 8'hED};

    rst = 1'b1; link_enable = 1'b1; link_ack = 1'b0;
    sync_q();
    @(negedge clk); @(negedge clk);
    chk("rst_valid", link_valid, 0);
    chk("rst_start", link_start, 0);
    chk("rst_read", queue_read, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", link_data, 0);
    chk("rst_sent", packets_sent, 0);
    chk("rst_sent_w4", s_packets_sent, 0);
    rst = 1'b0;

    // Table-driven single packets with optional stalls.
    for (int v = 0; v < 4; v++) begin
      clear_stats();
      hold_idx = vecs[v].stall_idx; stall_len_g = vecs[v].stall_len; stall_used = 0;
      s0 = exp_sent;
      push_pkt(vecs[v].pkt);
      k = 0;
      while (got_flits.size() < 4 && k < 40) begin step(1'b1, 2); k++; end
      step(1'b1, 1);
      chk("vec_flit_count", got_flits.size(), 4);
      for (int i = 0; i < 4 && i < got_flits.size(); i++)
        chk("vec_flit", got_flits[i], vecs[v].flits[3 - i]);
      chk("vec_first_valid", first_valid, 1);
      chk("vec_send_cycles", n_valid_cyc, vecs[v].send_cyc);
      chk("vec_reads", n_reads, 1);
      chk("vec_sent", packets_sent, 16'(s0 + 1));
      if (vecs[v].stall_len > 0) chk("vec_hold_cycles", n_hold, vecs[v].stall_len + 1);
    end
    hold_idx = -1;

    // Back-to-back packets with ack tied high.
    clear_stats();
    s0 = exp_sent;
    push_pkt(32'h3400CAFE);
    push_pkt(32'h4300FEED);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1);
      vb[9 - i] = last_valid;
    end
    chk("b2b_valid_pattern", vb, 10'b1111011110);
    chk("b2b_flit_count", got_flits.size(), 8);
    for (int i = 0; i < 8 && i < got_flits.size(); i++) chk("b2b_flit", got_flits[i], b2b[i]);
    chk("b2b_reads", rd_cyc.size(), 2);
    if (rd_cyc.size() == 2) chk("b2b_read_spacing", rd_cyc[1] - rd_cyc[0], 5);
    chk("b2b_sent", packets_sent, 16'(s0 + 2));

    // Link disabled: packet waits untouched, then goes once enabled.
    clear_stats();
    link_enable = 1'b0;
    push_pkt(32'h3200FACE);
    for (int i = 0; i < 20; i++) step(1'b0, 1);
    chk("dis_no_read", n_reads, 0);
    chk("dis_no_valid", n_valid_cyc, 0);
    chk("dis_queue_kept", txq.size(), 1);
    step(1'b1, 1);
    drain(20, "dis");
    chk("dis_flits", got_flits.size(), 4);
    if (got_flits.size() == 4) chk("dis_flit3", got_flits[3], 8'hCE);

    // Enable drops after the first flit: packet completes, next one stays queued.
    clear_stats();
    push_pkt(32'h3300ABCD);
    push_pkt(32'h12345678);
    step(1'b1, 1);
    for (int i = 0; i < 12; i++) step(1'b0, 1);
    chk("drop_flits", got_flits.size(), 4);
    if (got_flits.size() == 4) chk("drop_flit3", got_flits[3], 8'hCD);
    chk("drop_reads", n_reads, 1);
    chk("drop_queue_kept", txq.size(), 1);
    drain(20, "drop");

    // Asynchronous reset in the middle of flit 2.
    clear_stats();
    push_pkt(32'h3300DEED);
    step(1'b1, 1); step(1'b1, 1); step(1'b1, 0);
    chk("pre_rst_data", link_data, 8'hDE);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", link_valid, 0);
    chk("async_rst_start", link_start, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_sent", packets_sent, 0);
    exp_flits.delete(); flit_idx = 0; exp_sent = 0; prev_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    push_pkt(32'h2211AA55);
    drain(20, "post_rst");
    chk("post_rst_flits", got_flits.size(), 4);
    if (got_flits.size() == 4) chk("post_rst_flit0", got_flits[0], 8'h22);
    chk("post_rst_sent", packets_sent, 1);

    // 16 more packets: the 4-bit counter must land back where it started.
    s0 = exp_sent;
    for (int i = 0; i < 16; i++) push_pkt($urandom);
    drain(200, "wrap");
    chk("wrap_w4", s_packets_sent, 4'(s0));
    chk("wrap_main", packets_sent, 16'(s0 + 16));

    // Random traffic, acks and enable against the flit-stream model.
    for (int i = 0; i < 400; i++) begin
      if (($urandom % 4) == 0 && txq.size() < 6) push_pkt($urandom);
      step(($urandom % 10) != 0, (($urandom % 4) != 0) ? 1 : 0);
    end
    drain(200, "random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
